priority_encoder16: RTL and testbench

- Registered 16-to-4 request encoder; the inverse of the team's 4-to-16 one-hot decoder.
- Collects request pulses on 16 lines into a sticky pending register.
- Presents the index of one selected pending request as a 4-bit code, using a valid/ready handshake.
- Clears that request when it is accepted; it sits between interrupt/request sources and the consumer that drives the decoder select.

---
 rtl/priority_encoder16.sv | 114 +++++++++++
 tb/tb_priority_encoder16.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder16.sv
`default_nettype none
//==============================================================================
// Module      : priority_encoder16
// Description : Registered 16-to-4 request encoder. Request pulses are
//               collected in a sticky pending register. The index of one
//               selected pending request is presented on code with a
//               valid/ready handshake, and that request is cleared when the
//               consumer accepts it.
//               Optional macro PRIORITY_ENCODER16_RR_EN selects round-robin
//               arbitration. When the macro is undefined, the encoder uses
//               fixed priority, with the lowest index winning.
// Revision    : 1.0 - initial release
//==============================================================================
module priority_encoder16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        clr,
    output logic [3:0]  code,
    output logic        valid,
    input  logic        ready,
    output logic [15:0] pending,
    output logic        none
);

    logic [15:0] r_pending;
    logic [3:0]  r_code;
    logic        r_valid;
    logic        r_none;

    logic        w_grant;
    logic [15:0] w_gmask;
    logic [15:0] w_pend_next;
    logic        w_reload;
    logic [3:0]  w_base;
    logic [3:0]  w_idx;
    logic [3:0]  w_sel;

    assign w_grant  = r_valid & ready;
    assign w_gmask  = w_grant ? (16'd1 << r_code) : 16'd0;
    assign w_reload = ~r_valid | ready;

    // Drop the granted bit and merge in new requests. A re-raised request on the granted index survives. clr wipes everything.
    always_comb begin
        w_pend_next = (r_pending & ~w_gmask) | req;
        if (clr) begin
            w_pend_next = 16'd0;
        end
    end

`ifdef PRIORITY_ENCODER16_RR_EN
    logic [3:0] r_ptr;

    // The scan starts just past a granted code, so a reload in the same cycle already uses the advanced pointer.
    always_comb begin
        w_base = w_grant ? (r_code + 4'd1) : r_ptr;
    end

    // The round-robin pointer follows each accepted code. clr rewinds it to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 4'd0;
        end else if (clr) begin
            r_ptr <= 4'd0;
        end else if (w_grant) begin
            r_ptr <= r_code + 4'd1;
        end
    end
`else
    // With fixed priority, the scan always starts at index 0.
    always_comb begin
        w_base = 4'd0;
    end
`endif

    // The scan walks from base upward with wrap-around. It runs from the far end back, so the nearest set bit is written last and wins.
    always_comb begin
        w_sel = 4'd0;
        w_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            w_idx = w_base + 4'(i);
            if (w_pend_next[w_idx]) begin
                w_sel = w_idx;
            end
        end
    end

    // The pending register and output slot are updated here. The slot reloads only when it is empty or being accepted, so it stays frozen under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 16'd0;
            r_code    <= 4'd0;
            r_valid   <= 1'b0;
            r_none    <= 1'b1;
        end else begin
            r_pending <= w_pend_next;
            r_none    <= (w_pend_next == 16'd0);
            if (clr) begin
                r_valid <= 1'b0;
                r_code  <= 4'd0;
            end else if (w_reload) begin
                r_valid <= |w_pend_next;
                r_code  <= w_sel;
            end
        end
    end

    assign code    = r_code;
    assign valid   = r_valid;
    assign pending = r_pending;
    assign none    = r_none;

endmodule
`default_nettype wire

// File: tb/tb_priority_encoder16.sv
`default_nettype none
//==============================================================================
// Module      : tb_priority_encoder16
// Description : Scoreboard bench for priority_encoder16. The reference model
//               tracks the set of pending requests and the presented slot. It
//               predicts every accepted code and the state after each edge.
//               It follows PRIORITY_ENCODER16_RR_EN the same way the design
//               does.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_priority_encoder16;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        clr;
    logic        ready;
    logic [3:0]  code;
    logic        valid;
    logic [15:0] pending;
    logic        none;

    int n_cmp;
    int n_mis;

    // Reference model state
    bit [15:0] m_pend;
    bit        m_valid;
    int        m_code;
    int        m_ptr;
    int        exp_q[$];

    priority_encoder16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .clr     (clr),
        .code    (code),
        .valid   (valid),
        .ready   (ready),
        .pending (pending),
        .none    (none)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // First requested index met when walking upward from start, wrapping at 16
    function automatic int ref_select(input bit [15:0] p, input int start);
        for (int k = 0; k < 16; k++) begin
            int idx;
            idx = (start + k) % 16;
            if (p[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_code  = 0;
        m_ptr   = 0;
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pending"}, int'(pending), int'(m_pend));
        chk({tag, ".valid"},   int'(valid),   int'(m_valid));
        chk({tag, ".code"},    int'(code),    m_code);
        chk({tag, ".none"},    int'(none),    int'(m_pend == 16'd0));
    endtask

    // This task is called just after a rising edge. It drives one cycle, advances the model, then checks the state after the next edge.
    task automatic step(input logic [15:0] r, input logic c, input logic rd);
        bit g;
        req   = r;
        clr   = c;
        ready = rd;
        g = m_valid && rd;
        if (g) exp_q.push_back(m_code);
        if (c) begin
            m_pend  = '0;
            m_valid = 1'b0;
            m_code  = 0;
            m_ptr   = 0;
        end else begin
            if (g) begin
                m_pend[m_code] = 1'b0;
`ifdef PRIORITY_ENCODER16_RR_EN
                m_ptr = (m_code + 1) % 16;
`endif
            end
            m_pend = m_pend | r;
            if (!m_valid || rd) begin
                m_valid = (m_pend != 0);
                m_code  = m_valid ? ref_select(m_pend, m_ptr) : 0;
            end
        end
        @(posedge clk);
        #1;
        check_state("step");
    endtask

    // This task asserts reset mid-cycle. The outputs must clear with no clock edge.
    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        chk("rst.pending", int'(pending), 0);
        chk("rst.valid",   int'(valid),   0);
        chk("rst.code",    int'(code),    0);
        chk("rst.none",    int'(none),    1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // The monitor sees an accepted transfer mid-cycle and compares it with the next predicted grant.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL grant_unexpected: got code %0h expected no grant at %0t", code, $time);
            end else begin
                chk("grant_code", int'(code), exp_q.pop_front());
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst_n = 1'b0;
        req   = '0;
        clr   = 1'b0;
        ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        rst_n = 1'b1;

        // fixed drain of 16'h8421
        step(16'h8421, 1'b0, 1'b1);
        repeat (5) step(16'h0000, 1'b0, 1'b1);

        // back-pressure
        step(16'h0030, 1'b0, 1'b0);
        repeat (4) step(16'h0000, 1'b0, 1'b0);
        repeat (3) step(16'h0000, 1'b0, 1'b1);

        // re-raise on the granted index
        step(16'h0008, 1'b0, 1'b0);
        step(16'h0008, 1'b0, 1'b1);
        repeat (2) step(16'h0000, 1'b0, 1'b1);

        // clr overrides a full request word
        step(16'hFFFF, 1'b0, 1'b0);
        step(16'hFFFF, 1'b1, 1'b1);
        step(16'h0000, 1'b0, 1'b1);

        // held pair: alternates with round-robin, starves with fixed priority
        repeat (6) step(16'h0003, 1'b0, 1'b1);
        repeat (2) step(16'h0000, 1'b0, 1'b1);

        // wrap after granting index 15
        step(16'h8000, 1'b0, 1'b1);
        step(16'h8001, 1'b0, 1'b1);
        repeat (3) step(16'h0000, 1'b0, 1'b1);

        // asynchronous reset while a request is presented
        step(16'h8001, 1'b0, 1'b0);
        mid_reset();

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [15:0] r;
            r = ($urandom_range(0, 2) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0000;
            if ($urandom_range(0, 150) == 0) begin
                mid_reset();
            end else begin
                step(r, ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0));
            end
        end

        // drain, then every predicted grant must have been observed
        repeat (20) step(16'h0000, 1'b0, 1'b1);
        chk("grants_outstanding", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
